// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared constants, types and helpers for the instruction-fetch unit.
//   - ENABLE/DISABLE: instruction memory enable levels
//   - ZERO_WORD / NOP_INST: cleared word and the bubble instruction encoding
//   - PC_W, RESET_PC, EXC_PC: program counter width and redirect addresses
//   - fetch_state_e: fetch FSM state encodings
//   - align_word(): forces a byte address onto a word boundary
package fetch_unit_pkg;

  localparam int PC_W = 32;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [PC_W-1:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [PC_W-1:0] NOP_INST  = 32'h0000_0000;
  localparam logic [PC_W-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [PC_W-1:0] EXC_PC    = 32'h0000_0040;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// if_id_reg: IF/ID pipeline register between fetch and decode.
// Ports:
//   clk, rst        clock and synchronous active-high reset (clears the register)
//   bubble          replace contents with a nop bubble (pc 0, nop, invalid)
//   load            capture pc/inst as a valid entry
//   pc, inst        PC and instruction word coming from the fetch stage
//   id_pc, id_inst  registered PC and instruction presented to decode
//   id_valid        register holds a real instruction
// With neither bubble nor load asserted the register holds its contents.
module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            bubble,
  input  logic            load,
  input  logic [PC_W-1:0] pc,
  input  logic [31:0]     inst,
  output logic [PC_W-1:0] id_pc,
  output logic [31:0]     id_inst,
  output logic            id_valid
);

  // Reset and bubble both leave a cleared nop; bubble wins over load so a
  // wrong-path or out-of-range word can never be marked valid.
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      id_pc    <= ZERO_WORD;
      id_inst  <= NOP_INST;
      id_valid <= 1'b0;
    end else if (load) begin
      id_pc    <= pc;
      id_inst  <= inst;
      id_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch initiator. Owns the PC and the fetch FSM
// (IDLE/FETCH/HALT), drives the instruction memory request and fills the
// IF/ID register.
// Parameters:
//   MEM_WORDS       instruction memory depth in words; pc >= MEM_WORDS*4 halts
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   stall           hold PC and IF/ID
//   branch_flag     redirect to branch_target (word-aligned)
//   branch_target   redirect byte address
//   flush           exception redirect to EXC_PC
//   insEn, insAddr  instruction memory enable and word-aligned byte address
//   inst            word returned combinationally for insAddr
//   id_pc, id_inst, id_valid  IF/ID register contents
//   halted          high while the FSM is in HALT
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_flag,
  input  logic [PC_W-1:0] branch_target,
  input  logic            flush,
  output logic            insEn,
  output logic [PC_W-1:0] insAddr,
  input  logic [31:0]     inst,
  output logic [PC_W-1:0] id_pc,
  output logic [31:0]     id_inst,
  output logic            id_valid,
  output logic            halted
);

  // Limit is kept 34 bits wide so a 2^30-word memory (limit 2^32) never
  // reports an out-of-range PC.
  localparam logic [PC_W+1:0] PC_LIMIT = 34'(MEM_WORDS) * 34'd4;

  fetch_state_e    state;
  logic [PC_W-1:0] pc;
  logic            ins_en;
  logic            halted_q;
  logic            in_fetch;
  logic            out_of_range;
  logic            bubble;
  logic            load;

  assign in_fetch     = (state == FETCH);
  assign out_of_range = ({2'b00, pc} >= PC_LIMIT);

  // IF/ID takes a bubble on any redirect, outside FETCH, and when the word
  // being fetched lies past the end of memory; a stall leaves it untouched.
  assign bubble = flush | branch_flag | ~in_fetch | (~stall & out_of_range);
  assign load   = in_fetch & ~stall & ~out_of_range;

  assign insEn   = ins_en;
  assign insAddr = pc;
  assign halted  = halted_q;

  // PC and FSM share one block so the priority rst > flush > branch > stall
  // > advance is explicit; enable and halted are registered alongside the
  // state so they never depend combinationally on inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      state    <= IDLE;
      ins_en   <= DISABLE;
      halted_q <= 1'b0;
    end else if (flush) begin
      pc       <= EXC_PC;
      state    <= FETCH;
      ins_en   <= ENABLE;
      halted_q <= 1'b0;
    end else if (branch_flag) begin
      pc       <= align_word(branch_target);
      state    <= FETCH;
      ins_en   <= ENABLE;
      halted_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state  <= FETCH;
          ins_en <= ENABLE;
        end
        FETCH: begin
          if (!stall) begin
            if (out_of_range) begin
              state    <= HALT;
              ins_en   <= DISABLE;
              halted_q <= 1'b1;
            end else begin
              pc <= pc + 32'd4;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state    <= IDLE;
          ins_en   <= DISABLE;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .bubble   (bubble),
    .load     (load),
    .pc       (pc),
    .inst     (inst),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .id_valid (id_valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. Three instances share
// the control inputs: a 1024-word unit (table-driven vectors), a 4-word unit
// (end-of-memory halt) and a 2^30-word unit (PC wrap-around). Each has its
// own memory model returning word k = 0x1000_0000 + k.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branchFlag;
  logic [31:0] branchTarget;
  logic        flush;

  logic        enM, enS, enW;
  logic [31:0] addrM, addrS, addrW;
  logic [31:0] instM, instS, instW;
  logic [31:0] idPcM, idPcS, idPcW;
  logic [31:0] idInstM, idInstS, idInstW;
  logic        validM, validS, validW;
  logic        haltM, haltS, haltW;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        branch;
    logic [31:0] target;
    logic        flush;
    logic        en;
    logic [31:0] addr;
    logic [31:0] idPc;
    logic [31:0] idInst;
    logic        idValid;
    logic        halted;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign instM = memWord(addrM);
  assign instS = memWord(addrS);
  assign instW = memWord(addrW);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  fetch_unit #(.MEM_WORDS(1024)) dutMain (
    .clk(clk), .rst(rst), .stall(stall), .branch_flag(branchFlag),
    .branch_target(branchTarget), .flush(flush), .insEn(enM), .insAddr(addrM),
    .inst(instM), .id_pc(idPcM), .id_inst(idInstM), .id_valid(validM), .halted(haltM)
  );

  fetch_unit #(.MEM_WORDS(4)) dutSmall (
    .clk(clk), .rst(rst), .stall(stall), .branch_flag(branchFlag),
    .branch_target(branchTarget), .flush(flush), .insEn(enS), .insAddr(addrS),
    .inst(instS), .id_pc(idPcS), .id_inst(idInstS), .id_valid(validS), .halted(haltS)
  );

  fetch_unit #(.MEM_WORDS(32'h4000_0000)) dutWrap (
    .clk(clk), .rst(rst), .stall(stall), .branch_flag(branchFlag),
    .branch_target(branchTarget), .flush(flush), .insEn(enW), .insAddr(addrW),
    .inst(instW), .id_pc(idPcW), .id_inst(idInstW), .id_valid(validW), .halted(haltW)
  );

  task automatic applyStimulus(input logic r, input logic s, input logic b,
                               input logic [31:0] t, input logic f);
    rst          = r;
    stall        = s;
    branchFlag   = b;
    branchTarget = t;
    flush        = f;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic addVec(input int i, input logic r, input logic s, input logic b,
                        input logic [31:0] t, input logic f, input logic en,
                        input logic [31:0] addr, input logic [31:0] idPc,
                        input logic [31:0] idInst, input logic idValid,
                        input logic halted);
    vecs[i] = '{r, s, b, t, f, en, addr, idPc, idInst, idValid, halted};
  endtask

  // Outputs are all registered, so each vector checks the values visible in
  // its cycle and then drives the inputs that act on the following edge.
  initial begin
    addVec(0,  0, 0, 0, 32'h0,   0, 0, 32'h00, 32'h00, 32'h0000_0000, 0, 0);
    addVec(1,  0, 0, 0, 32'h0,   0, 1, 32'h00, 32'h00, 32'h0000_0000, 0, 0);
    addVec(2,  0, 0, 0, 32'h0,   0, 1, 32'h04, 32'h00, 32'h1000_0000, 1, 0);
    addVec(3,  0, 1, 0, 32'h0,   0, 1, 32'h08, 32'h04, 32'h1000_0001, 1, 0);
    addVec(4,  0, 1, 0, 32'h0,   0, 1, 32'h08, 32'h04, 32'h1000_0001, 1, 0);
    addVec(5,  0, 1, 0, 32'h0,   0, 1, 32'h08, 32'h04, 32'h1000_0001, 1, 0);
    addVec(6,  0, 0, 0, 32'h0,   0, 1, 32'h08, 32'h04, 32'h1000_0001, 1, 0);
    addVec(7,  0, 1, 1, 32'h23,  0, 1, 32'h0C, 32'h08, 32'h1000_0002, 1, 0);
    addVec(8,  0, 0, 0, 32'h0,   0, 1, 32'h20, 32'h00, 32'h0000_0000, 0, 0);
    addVec(9,  1, 0, 1, 32'h100, 0, 1, 32'h24, 32'h20, 32'h1000_0008, 1, 0);
    addVec(10, 0, 0, 0, 32'h0,   0, 0, 32'h00, 32'h00, 32'h0000_0000, 0, 0);
    addVec(11, 0, 0, 0, 32'h0,   1, 1, 32'h00, 32'h00, 32'h0000_0000, 0, 0);
    addVec(12, 0, 0, 0, 32'h0,   0, 1, 32'h40, 32'h00, 32'h0000_0000, 0, 0);
    addVec(13, 0, 0, 0, 32'h0,   0, 1, 32'h44, 32'h40, 32'h1000_0010, 1, 0);

    applyStimulus(1, 0, 0, 32'h0, 0);
    repeat (2) @(posedge clk);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      checkOutput($sformatf("vec%0d.insEn", i),    {31'b0, enM},    {31'b0, vecs[i].en});
      checkOutput($sformatf("vec%0d.insAddr", i),  addrM,           vecs[i].addr);
      checkOutput($sformatf("vec%0d.id_pc", i),    idPcM,           vecs[i].idPc);
      checkOutput($sformatf("vec%0d.id_inst", i),  idInstM,         vecs[i].idInst);
      checkOutput($sformatf("vec%0d.id_valid", i), {31'b0, validM}, {31'b0, vecs[i].idValid});
      checkOutput($sformatf("vec%0d.halted", i),   {31'b0, haltM},  {31'b0, vecs[i].halted});
      applyStimulus(vecs[i].rst, vecs[i].stall, vecs[i].branch, vecs[i].target, vecs[i].flush);
    end

    // End-of-memory halt on the 4-word unit, then flush recovery.
    @(negedge clk);
    applyStimulus(1, 0, 0, 32'h0, 0);
    @(negedge clk);
    checkOutput("small.cycle0.insEn", {31'b0, enS}, 32'd0);
    applyStimulus(0, 0, 0, 32'h0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("small.run%0d.insAddr", k), addrS, 32'(4 * k));
      checkOutput($sformatf("small.run%0d.insEn", k), {31'b0, enS}, 32'd1);
    end
    @(negedge clk);
    checkOutput("small.pc10.insAddr", addrS, 32'h10);
    checkOutput("small.pc10.id_pc", idPcS, 32'h0C);
    checkOutput("small.pc10.id_inst", idInstS, 32'h1000_0003);
    checkOutput("small.pc10.id_valid", {31'b0, validS}, 32'd1);
    @(negedge clk);
    checkOutput("small.halt.halted", {31'b0, haltS}, 32'd1);
    checkOutput("small.halt.insEn", {31'b0, enS}, 32'd0);
    checkOutput("small.halt.id_valid", {31'b0, validS}, 32'd0);
    checkOutput("small.halt.insAddr", addrS, 32'h10);
    @(negedge clk);
    checkOutput("small.halt2.halted", {31'b0, haltS}, 32'd1);
    applyStimulus(0, 0, 0, 32'h0, 1);
    @(negedge clk);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("small.flush.insAddr", addrS, 32'h40);
    checkOutput("small.flush.insEn", {31'b0, enS}, 32'd1);
    checkOutput("small.flush.halted", {31'b0, haltS}, 32'd0);
    checkOutput("small.flush.id_valid", {31'b0, validS}, 32'd0);
    @(negedge clk);
    checkOutput("small.exc_oor.halted", {31'b0, haltS}, 32'd1);

    // PC wrap-around on the 2^30-word unit via an unaligned branch target.
    applyStimulus(0, 0, 1, 32'hFFFF_FFFF, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("wrap.target.insAddr", addrW, 32'hFFFF_FFFC);
    checkOutput("wrap.target.id_valid", {31'b0, validW}, 32'd0);
    @(negedge clk);
    checkOutput("wrap.next.insAddr", addrW, 32'h0000_0000);
    checkOutput("wrap.next.id_pc", idPcW, 32'hFFFF_FFFC);
    checkOutput("wrap.next.id_inst", idInstW, 32'h4FFF_FFFF);
    checkOutput("wrap.next.id_valid", {31'b0, validW}, 32'd1);
    checkOutput("wrap.next.halted", {31'b0, haltW}, 32'd0);
    @(negedge clk);
    checkOutput("wrap.after.insAddr", addrW, 32'h0000_0004);
    checkOutput("wrap.after.id_pc", idPcW, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
